// File: rtl/rsub_divider_pkg.sv
// Shared definitions for the repeated-subtraction divider: controller state
// encoding and the divide-by-zero quotient pattern.
package div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SUB  = 2'd1,
        DONE = 2'd2
    } state_t;

    // All-ones quotient reported on divide-by-zero (reads as -1 in signed mode).
    function automatic logic [63:0] DBZ_QUOTIENT(input int width);
        if (width >= 64)
            return '1;
        return (64'd1 << width) - 64'd1;
    endfunction

endpackage

// File: rtl/rsub_divider_if.sv
// Host <-> divider handshake: start pulse with operands in, busy/done and
// registered results out.
interface rsub_divider_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             dbz;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, dbz
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, dbz
    );
endinterface

// File: rtl/rsub_divider_datapath.sv
// Working registers R/D/Q, subtractor, comparator and result registers.
// Optional macro RSUB_DIVIDER_SIGNED_EN adds magnitude pre-conditioning and
// sign post-conditioning (truncating division); otherwise purely unsigned.
module rsub_datapath
    import div_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             sub_en,
    input  logic             commit,
    input  logic             dbz_sel,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             ge,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);
    localparam logic [WIDTH-1:0] DBZ_Q = WIDTH'(DBZ_QUOTIENT(WIDTH));

    logic [WIDTH-1:0] r, d, q;
    logic [WIDTH-1:0] a_in, b_in;
    logic [WIDTH-1:0] q_fix, r_fix;

`ifdef RSUB_DIVIDER_SIGNED_EN
    logic neg_q, neg_r;

    // Magnitude of a two's complement value; -2^(WIDTH-1) maps to itself,
    // which is the correct unsigned magnitude.
    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v);
        return v[WIDTH-1] ? (~v + WIDTH'(1)) : v;
    endfunction

    assign a_in  = mag(dividend);
    assign b_in  = mag(divisor);
    assign q_fix = neg_q ? (~q + WIDTH'(1)) : q;
    assign r_fix = neg_r ? (~r + WIDTH'(1)) : r;

    // Operand signs captured at start decide the result signs at commit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            neg_q <= 1'b0;
            neg_r <= 1'b0;
        end else if (load) begin
            neg_q <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
            neg_r <= dividend[WIDTH-1];
        end
    end
`else
    assign a_in  = dividend;
    assign b_in  = divisor;
    assign q_fix = q;
    assign r_fix = r;
`endif

    assign ge = (r >= d);

    // Working registers: load operands, then one subtraction per enabled cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r <= '0;
            d <= '0;
            q <= '0;
        end else if (load) begin
            r <= a_in;
            d <= b_in;
            q <= '0;
        end else if (sub_en) begin
            r <= r - d;
            q <= q + WIDTH'(1);
        end
    end

    // Result registers update only on commit and otherwise hold the last result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            quotient  <= '0;
            remainder <= '0;
        end else if (commit) begin
            quotient  <= dbz_sel ? DBZ_Q : q_fix;
            remainder <= r_fix;
        end
    end
endmodule

// File: rtl/rsub_divider.sv
// Repeated-subtraction divider: IDLE/SUB/DONE controller driving rsub_datapath.
// Optional macro RSUB_DIVIDER_SIGNED_EN selects two's complement operands.
module rsub_divider
    import div_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                clk,
    input  logic                rst,
    rsub_divider_if.slave       bus
);
    state_t           state;
    logic             busy_r, done_r, dbz_r;
    logic             dbz_pend;
    logic             ge;
    logic             load, sub_en, commit;
    logic [WIDTH-1:0] quotient, remainder;

    // A zero divisor still spends one cycle in SUB (no subtraction) so that
    // divide-by-zero has the same two-edge latency as a zero quotient.
    assign load   = (state == IDLE) && bus.start;
    assign commit = (state == SUB) && (dbz_pend || !ge);
    assign sub_en = (state == SUB) && !dbz_pend && ge;

    // Controller FSM with registered handshake outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            dbz_r    <= 1'b0;
            dbz_pend <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done_r <= 1'b0;
                    if (bus.start) begin
                        busy_r   <= 1'b1;
                        dbz_pend <= (bus.divisor == '0);
                        state    <= SUB;
                    end
                end
                SUB: begin
                    if (dbz_pend || !ge) begin
                        busy_r <= 1'b0;
                        done_r <= 1'b1;
                        dbz_r  <= dbz_pend;
                        state  <= DONE;
                    end
                end
                DONE: begin
                    done_r <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    rsub_datapath #(.WIDTH(WIDTH)) u_dp (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .sub_en    (sub_en),
        .commit    (commit),
        .dbz_sel   (dbz_pend),
        .dividend  (bus.dividend),
        .divisor   (bus.divisor),
        .ge        (ge),
        .quotient  (quotient),
        .remainder (remainder)
    );

    assign bus.busy      = busy_r;
    assign bus.done      = done_r;
    assign bus.dbz       = dbz_r;
    assign bus.quotient  = quotient;
    assign bus.remainder = remainder;
endmodule

// File: tb/tb_rsub_divider.sv
// Self-checking bench for rsub_divider (WIDTH=8): directed plan cases plus
// randomized operands against an arithmetic reference model.
module tb_rsub_divider;
    localparam int W = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests = 0;
    int   fails = 0;

    rsub_divider_if #(.WIDTH(W)) bus ();

    rsub_divider #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Reference: plain integer division; latency = magnitude quotient + 2.
    function automatic void ref_div(input logic [W-1:0] a, input logic [W-1:0] b,
                                    output logic [W-1:0] q, output logic [W-1:0] r,
                                    output logic z, output int lat);
        int sa, sb;
`ifdef RSUB_DIVIDER_SIGNED_EN
        sa = int'($signed(a));
        sb = int'($signed(b));
`else
        sa = int'({24'd0, a});
        sb = int'({24'd0, b});
`endif
        if (sb == 0) begin
            q = '1; r = a; z = 1'b1; lat = 2;
        end else begin
            q = W'(sa / sb);
            r = W'(sa % sb);
            z = 1'b0;
            lat = ((sa < 0 ? -sa : sa) / (sb < 0 ? -sb : sb)) + 2;
        end
    endfunction

    // Drive one division; report edge count to done, results and busy errors.
    task automatic do_div(input logic [W-1:0] a, input logic [W-1:0] b,
                          output int lat, output logic [W-1:0] q, output logic [W-1:0] r,
                          output logic z, output int busy_err);
        int cnt;
        busy_err = 0;
        @(negedge clk);
        bus.start = 1'b1; bus.dividend = a; bus.divisor = b;
        @(posedge clk); #1;
        bus.start = 1'b0; bus.dividend = W'($urandom); bus.divisor = W'($urandom);
        cnt = 1;
        if (!bus.done && !bus.busy) busy_err++;
        while (!bus.done && cnt < 600) begin
            @(posedge clk); #1;
            cnt++;
            if (!bus.done && !bus.busy) busy_err++;
        end
        if (bus.done && bus.busy) busy_err++;
        lat = bus.done ? cnt : -1;
        q = bus.quotient; r = bus.remainder; z = bus.dbz;
    endtask

    task automatic test_reset;
        bus.start = 1'b0; bus.dividend = '0; bus.divisor = '0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b want 0", bus.busy); end
        tests++; if (bus.done !== 1'b0) begin fails++; $display("FAIL reset_done got %b want 0", bus.done); end
        tests++; if (bus.quotient !== '0) begin fails++; $display("FAIL reset_q got %h want 00", bus.quotient); end
        tests++; if (bus.remainder !== '0) begin fails++; $display("FAIL reset_r got %h want 00", bus.remainder); end
        tests++; if (bus.dbz !== 1'b0) begin fails++; $display("FAIL reset_dbz got %b want 0", bus.dbz); end
        @(negedge clk); rst = 1'b0;
    endtask

    task automatic test_directed;
        logic [W-1:0] av [5] = '{8'd200, 8'd5, 8'd255, 8'd13, 8'd12};
        logic [W-1:0] bv [5] = '{8'd7,   8'd9, 8'd1,   8'd0,  8'd4};
        for (int i = 0; i < 5; i++) begin
            int lat, elat, be;
            logic [W-1:0] q, r, eq, er;
            logic z, ez;
            ref_div(av[i], bv[i], eq, er, ez, elat);
            do_div(av[i], bv[i], lat, q, r, z, be);
            tests++; if (lat !== elat) begin fails++; $display("FAIL dir_lat %0d/%0d got %0d want %0d", av[i], bv[i], lat, elat); end
            tests++; if (q !== eq) begin fails++; $display("FAIL dir_q %0d/%0d got %h want %h", av[i], bv[i], q, eq); end
            tests++; if (r !== er) begin fails++; $display("FAIL dir_r %0d/%0d got %h want %h", av[i], bv[i], r, er); end
            tests++; if (z !== ez) begin fails++; $display("FAIL dir_dbz %0d/%0d got %b want %b", av[i], bv[i], z, ez); end
            tests++; if (be !== 0) begin fails++; $display("FAIL dir_busy %0d/%0d got %0d errors want 0", av[i], bv[i], be); end
            @(posedge clk); #1;
            tests++; if (bus.done !== 1'b0) begin fails++; $display("FAIL dir_done_pulse got %b want 0", bus.done); end
            tests++; if (bus.quotient !== eq) begin fails++; $display("FAIL dir_hold_q got %h want %h", bus.quotient, eq); end
        end
    endtask

    task automatic test_rst_mid;
        int lat, elat, be;
        logic [W-1:0] q, r, eq, er;
        logic z, ez;
        @(negedge clk);
        bus.start = 1'b1; bus.dividend = 8'd255; bus.divisor = 8'd1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (9) @(posedge clk);
        #1; rst = 1'b1; #1;
        tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL rstmid_busy got %b want 0", bus.busy); end
        tests++; if (bus.quotient !== '0 || bus.remainder !== '0 || bus.dbz !== 1'b0 || bus.done !== 1'b0)
            begin fails++; $display("FAIL rstmid_outs got q=%h r=%h dbz=%b done=%b want all 0", bus.quotient, bus.remainder, bus.dbz, bus.done); end
        @(negedge clk); rst = 1'b0;
        ref_div(8'd9, 8'd3, eq, er, ez, elat);
        do_div(8'd9, 8'd3, lat, q, r, z, be);
        tests++; if (q !== eq || r !== er || lat !== elat)
            begin fails++; $display("FAIL rstmid_next got q=%h r=%h lat=%0d want q=%h r=%h lat=%0d", q, r, lat, eq, er, elat); end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back;
        int edges[$];
        int bad_q = 0;
        int elat;
        logic [W-1:0] eq, er;
        logic ez;
        ref_div(8'd20, 8'd5, eq, er, ez, elat);
        @(negedge clk);
        bus.start = 1'b1; bus.dividend = 8'd20; bus.divisor = 8'd5;
        for (int e = 1; e <= 40; e++) begin
            @(posedge clk); #1;
            if (bus.done) begin
                edges.push_back(e);
                if (bus.quotient !== eq) bad_q++;
            end
        end
        @(negedge clk); bus.start = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        // done at elat, then every elat+1 edges (one DONE cycle, one IDLE cycle).
        tests++; if (edges.size() != (40 - elat) / (elat + 1) + 1)
            begin fails++; $display("FAIL b2b_count got %0d want %0d", edges.size(), (40 - elat) / (elat + 1) + 1); end
        foreach (edges[k]) begin
            tests++; if (edges[k] != elat + k * (elat + 1))
                begin fails++; $display("FAIL b2b_edge[%0d] got %0d want %0d", k, edges[k], elat + k * (elat + 1)); end
        end
        tests++; if (bad_q != 0) begin fails++; $display("FAIL b2b_q got %0d bad quotients want 0", bad_q); end
    endtask

    task automatic test_random;
        for (int i = 0; i < 40; i++) begin
            int lat, elat, be;
            logic [W-1:0] a, b, q, r, eq, er;
            logic z, ez;
            a = W'($urandom);
            b = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom_range(1, 255));
            ref_div(a, b, eq, er, ez, elat);
            do_div(a, b, lat, q, r, z, be);
            tests++; if (q !== eq || r !== er || z !== ez || lat !== elat || be !== 0)
                begin fails++; $display("FAIL rand %h/%h got q=%h r=%h dbz=%b lat=%0d busyerr=%0d want q=%h r=%h dbz=%b lat=%0d",
                                        a, b, q, r, z, lat, be, eq, er, ez, elat); end
            @(posedge clk); #1;
        end
    endtask

`ifdef RSUB_DIVIDER_SIGNED_EN
    task automatic test_signed;
        logic [W-1:0] av [4] = '{8'hF9, 8'h07, 8'h80, 8'hFB};
        logic [W-1:0] bv [4] = '{8'h02, 8'hFE, 8'hFF, 8'h00};
        logic [W-1:0] qv [4] = '{8'hFD, 8'hFD, 8'h80, 8'hFF};
        logic [W-1:0] rv [4] = '{8'hFF, 8'h01, 8'h00, 8'hFB};
        for (int i = 0; i < 4; i++) begin
            int lat, be;
            logic [W-1:0] q, r;
            logic z;
            do_div(av[i], bv[i], lat, q, r, z, be);
            tests++; if (q !== qv[i] || r !== rv[i])
                begin fails++; $display("FAIL signed %h/%h got q=%h r=%h want q=%h r=%h", av[i], bv[i], q, r, qv[i], rv[i]); end
            @(posedge clk); #1;
        end
    endtask
`endif

    initial begin
        test_reset();
        test_directed();
        test_rst_mid();
        test_back_to_back();
`ifdef RSUB_DIVIDER_SIGNED_EN
        test_signed();
`endif
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
